// File: rtl/ctrl_pipe_dec_if.sv
// Handshake and control bus between the RV32 hazard/fetch logic and the
// main decoder pipeline. The master side drives the D-stage inputs; the
// slave side (the decoder) returns decoded and pipelined control bits.
interface ctrl_pipe_dec_if #(
  parameter int ALUOP_W = 2
);
  logic               ihit;
  logic               dhit;
  logic [31:0]        instr;
  logic               flush_e;
  logic               d_branch;
  logic               d_jump;
  logic               d_illegal;
  logic               stall_fd;
  logic               e_alu_src;
  logic [ALUOP_W-1:0] e_aluop;
  logic               e_load;
  logic [4:0]         e_rd;
  logic               m_mem_write;
  logic               m_byte;
  logic               w_reg_write;
  logic               w_mem_to_reg;
  logic               w_byte;
  logic [4:0]         w_rd;

  modport master (
    output ihit, dhit, instr, flush_e,
    input  d_branch, d_jump, d_illegal, stall_fd,
           e_alu_src, e_aluop, e_load, e_rd,
           m_mem_write, m_byte,
           w_reg_write, w_mem_to_reg, w_byte, w_rd
  );

  modport slave (
    input  ihit, dhit, instr, flush_e,
    output d_branch, d_jump, d_illegal, stall_fd,
           e_alu_src, e_aluop, e_load, e_rd,
           m_mem_write, m_byte,
           w_reg_write, w_mem_to_reg, w_byte, w_rd
  );
endinterface

// File: rtl/ctrl_pipe_dec.sv
// Main decoder plus control pipeline D -> E -> M1..M[MEM_LAT] -> W.
// Provides load-use interlock, branch/jump flush of E, illegal-op flag and
// optional MUL / byte-access decode.
module ctrl_pipe_dec #(
  parameter int MEM_LAT = 1,
  parameter int MUL_EN  = 1,
  parameter int BYTE_EN = 1,
  parameter int ALUOP_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  ctrl_pipe_dec_if.slave  bus
);

  // Control word layout: {rw, mw, ld, br, jp, by, as, m2r, aluop[1:0]}
  localparam logic [9:0] CW_LB   = 10'b1010011100;
  localparam logic [9:0] CW_LW   = 10'b1010001100;
  localparam logic [9:0] CW_SB   = 10'b0100011000;
  localparam logic [9:0] CW_SW   = 10'b0100001000;
  localparam logic [9:0] CW_BEQ  = 10'b0001000001;
  localparam logic [9:0] CW_JMP  = 10'b1000100000;
  localparam logic [9:0] CW_ADDI = 10'b1000001000;
  localparam logic [9:0] CW_RTYP = 10'b1000000010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Control bits that travel past D; branch/jump are consumed in D only.
  typedef struct packed {
    logic               rw;
    logic               mw;
    logic               ld;
    logic               by;
    logic               as;
    logic               m2r;
    logic [ALUOP_W-1:0] aluop;
    logic [4:0]         rd;
  } stage_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd_d;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [9:0] w_word;
  logic       w_legal;
  logic [9:0] w_ctrl;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_hazard;
  stage_t     w_dec;

  stage_t                   r_e;
  stage_t [MEM_LAT-1:0]     r_m;
  stage_t                   r_w;

  assign w_opcode = bus.instr[6:0];
  assign w_rd_d   = bus.instr[11:7];
  assign w_funct3 = bus.instr[14:12];
  assign w_rs1    = bus.instr[19:15];
  assign w_rs2    = bus.instr[24:20];
  assign w_funct7 = bus.instr[31:25];

  // Table decode of the D-stage opcode/funct fields into a raw control word.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_word  = 10'b0;
    w_legal = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        if (w_funct3 == 3'b000 && BYTE_EN != 0) begin
          w_word = CW_LB; w_legal = 1'b1;
        end else if (w_funct3 == 3'b010) begin
          w_word = CW_LW; w_legal = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b000 && BYTE_EN != 0) begin
          w_word = CW_SB; w_legal = 1'b1;
        end else if (w_funct3 == 3'b010) begin
          w_word = CW_SW; w_legal = 1'b1;
        end
      end
      OP_BRANCH: if (w_funct3 == 3'b000) begin w_word = CW_BEQ;  w_legal = 1'b1; end
      OP_JAL:    begin                          w_word = CW_JMP;  w_legal = 1'b1; end
      OP_JALR:   if (w_funct3 == 3'b000) begin w_word = CW_JMP;  w_legal = 1'b1; end
      OP_IMM:    if (w_funct3 == 3'b000) begin w_word = CW_ADDI; w_legal = 1'b1; end
      OP_REG: begin
        if (w_funct3 == 3'b000 &&
            (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000 ||
             (w_funct7 == 7'b0000001 && MUL_EN != 0))) begin
          w_word = CW_RTYP; w_legal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // An empty D slot decodes as a NOP; an illegal encoding yields all-zero controls.
  assign w_ctrl        = (bus.ihit && w_legal) ? w_word : 10'b0;
  assign bus.d_illegal = bus.ihit & ~w_legal;
  assign bus.d_branch  = w_ctrl[6];
  assign bus.d_jump    = w_ctrl[5];

  // Destination is kept only for instructions that write back.
  assign w_dec = '{rw:    w_ctrl[9],
                   mw:    w_ctrl[8],
                   ld:    w_ctrl[7],
                   by:    w_ctrl[4],
                   as:    w_ctrl[3],
                   m2r:   w_ctrl[2],
                   aluop: ALUOP_W'(w_ctrl[1:0]),
                   rd:    w_ctrl[9] ? w_rd_d : 5'd0};

  // Load-use interlock: the load in E has not produced data yet.
  assign w_use_rs1 = bus.ihit & (w_opcode != OP_JAL);
  assign w_use_rs2 = bus.ihit & ((w_opcode == OP_STORE) || (w_opcode == OP_BRANCH) ||
                                 (w_opcode == OP_REG));
  assign w_hazard  = r_e.ld && (r_e.rd != 5'd0) &&
                     (((r_e.rd == w_rs1) && w_use_rs1) || ((r_e.rd == w_rs2) && w_use_rs2));

  assign bus.stall_fd = ~bus.dhit | (~bus.flush_e & w_hazard);

  // Stage registers: reset empties, dhit=0 freezes, flush/hazard bubble E.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift is order-independent.
  // NOTE: the M-stage array is control state, not storage, so it is reset
  // along with the rest; an empty pipeline must never replay stale writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (bus.dhit) begin
      r_e    <= (bus.flush_e || w_hazard) ? stage_t'('0) : w_dec;
      r_m[0] <= r_e;
      for (int i = 1; i < MEM_LAT; i++) r_m[i] <= r_m[i-1];
      r_w    <= r_m[MEM_LAT-1];
    end
  end

  assign bus.e_alu_src    = r_e.as;
  assign bus.e_aluop      = r_e.aluop;
  assign bus.e_load       = r_e.ld;
  assign bus.e_rd         = r_e.rd;
  assign bus.m_mem_write  = r_m[0].mw;
  assign bus.m_byte       = r_m[0].by;
  assign bus.w_reg_write  = r_w.rw;
  assign bus.w_mem_to_reg = r_w.m2r;
  assign bus.w_byte       = r_w.by & r_w.ld;
  assign bus.w_rd         = r_w.rd;

  // Fields carried for uniformity but not observed at W.
  logic w_unused;
  assign w_unused = &{1'b0, r_w.mw, r_w.as, r_w.aluop};

endmodule
